// File: rtl/conv_encoder_punct.sv
`timescale 1ns/1ps
// Rate-1/2 feed-forward convolutional encoder with 1/2, 2/3, 3/4 puncturing, optional zero tail, serial coded-bit output.
// Latency: first coded bit is valid the cycle after an input bit is accepted; one info bit per (kept bits + 1) cycles.
// Backpressure: in_ready only while IDLE; out_ready low freezes all state, so no coded bit is lost or repeated.
module conv_encoder_punct #(
    parameter int             K         = 3,
    parameter logic [K-1:0]   G0        = 3'b111,
    parameter logic [K-1:0]   G1        = 3'b101,
    parameter bit             TERMINATE = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] rate,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_data,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_bit,
    output logic       out_last,
    output logic       busy
);

    localparam int SW  = K - 1;
    localparam int TCW = $clog2(K);

    localparam logic [1:0] RATE_12 = 2'b00;
    localparam logic [1:0] RATE_23 = 2'b01;
    localparam logic [1:0] RATE_34 = 2'b10;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        EMIT0 = 3'd1,
        EMIT1 = 3'd2,
        TAIL0 = 3'd3,
        TAIL1 = 3'd4
    } state_t;

    state_t         state;
    state_t         state_nxt;

    // sreg[SW-1] is the most recent information bit (s[0]), sreg[0] the oldest.
    logic [SW-1:0]  sreg;
    logic [1:0]     phase;
    logic [1:0]     rate_q;
    logic [TCW-1:0] tail_cnt;
    logic           c0_q;
    logic           c1_q;
    logic           keep1_q;
    logic           last_q;
    logic           busy_q;

    // FSM-generated strobes consumed by the datapath register block
    logic           accept;
    logic           bit_done;
    logic           tail_load;
    logic           tail_step;
    logic           frame_end;

    // Encoder-side combinational values
    logic           first_bit;
    logic [1:0]     rate_in_eff;
    logic [1:0]     rate_eff;
    logic [1:0]     phase_eff;
    logic           keep0_in;
    logic           keep1_in;
    logic           enc_c0;
    logic           enc_c1;
    logic           tail_c0;
    logic           tail_c1;
    logic [1:0]     phase_nxt;

    // Parity of the generator taps over {current input, shift register}
    function automatic logic parity(input logic [K-1:0] g, input logic b, input logic [SW-1:0] s);
        return ^(g & {b, s});
    endfunction

    // A frame starts on the first accepted bit while no frame is open; the
    // reserved rate code falls back to 1/2, and the frame uses the rate/phase
    // seen at its start rather than whatever rate shows later.
    always_comb begin
        first_bit   = !busy_q;
        rate_in_eff = (rate == 2'b11) ? RATE_12 : rate;
        rate_eff    = first_bit ? rate_in_eff : rate_q;
        phase_eff   = first_bit ? 2'd0 : phase;

        // Only phase 2 of rate 3/4 drops c0; c1 survives at phase 0 of every
        // rate, always at 1/2, and at phase 2 of 3/4. No phase drops both.
        keep0_in = !((rate_eff == RATE_34) && (phase_eff == 2'd2));
        keep1_in = (rate_eff == RATE_12) || (phase_eff == 2'd0) ||
                   ((rate_eff == RATE_34) && (phase_eff == 2'd2));

        enc_c0  = parity(G0, in_data, sreg);
        enc_c1  = parity(G1, in_data, sreg);
        tail_c0 = parity(G0, 1'b0, sreg);
        tail_c1 = parity(G1, 1'b0, sreg);
    end

    // Phase wraps with the puncture period of the rate latched for the frame
    always_comb begin
        phase_nxt = 2'd0;
        case (rate_q)
            RATE_23: phase_nxt = (phase == 2'd1) ? 2'd0 : phase + 2'd1;
            RATE_34: phase_nxt = (phase == 2'd2) ? 2'd0 : phase + 2'd1;
            default: phase_nxt = 2'd0;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state, handshake outputs and datapath strobes
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_bit   = 1'b0;
        out_last  = 1'b0;
        accept    = 1'b0;
        bit_done  = 1'b0;
        tail_load = 1'b0;
        tail_step = 1'b0;
        frame_end = 1'b0;

        case (state)
            IDLE: begin
                // Gated by reset so the source sees not-ready while reset is held
                in_ready = !reset;
                if (in_valid && !reset) begin
                    accept    = 1'b1;
                    state_nxt = keep0_in ? EMIT0 : EMIT1;
                end
            end

            EMIT0: begin
                out_valid = 1'b1;
                out_bit   = c0_q;
                out_last  = last_q && !keep1_q && !TERMINATE;
                if (out_ready) begin
                    if (keep1_q) begin
                        state_nxt = EMIT1;
                    end else begin
                        bit_done = 1'b1;
                    end
                end
            end

            EMIT1: begin
                out_valid = 1'b1;
                out_bit   = c1_q;
                out_last  = last_q && !TERMINATE;
                if (out_ready) begin
                    bit_done = 1'b1;
                end
            end

            TAIL0: begin
                out_valid = 1'b1;
                out_bit   = tail_c0;
                if (out_ready) begin
                    state_nxt = TAIL1;
                end
            end

            TAIL1: begin
                out_valid = 1'b1;
                out_bit   = tail_c1;
                out_last  = (tail_cnt == TCW'(1));
                if (out_ready) begin
                    tail_step = 1'b1;
                    if (tail_cnt == TCW'(1)) begin
                        frame_end = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = TAIL0;
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Last kept bit of an information bit: wait for the next one, start the
        // tail, or close the frame straight away when termination is off.
        if (bit_done) begin
            if (!last_q) begin
                state_nxt = IDLE;
            end else if (TERMINATE) begin
                state_nxt = TAIL0;
                tail_load = 1'b1;
            end else begin
                state_nxt = IDLE;
                frame_end = 1'b1;
            end
        end
    end

    // Encoder datapath: coded-bit latches, shift register, phase, tail count, frame tracking
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sreg     <= '0;
            phase    <= 2'd0;
            rate_q   <= RATE_12;
            tail_cnt <= '0;
            c0_q     <= 1'b0;
            c1_q     <= 1'b0;
            keep1_q  <= 1'b0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            if (accept) begin
                c0_q    <= enc_c0;
                c1_q    <= enc_c1;
                keep1_q <= keep1_in;
                last_q  <= in_last;
                sreg    <= {in_data, sreg[SW-1:1]};
                phase   <= phase_eff;
                busy_q  <= 1'b1;
                if (first_bit) begin
                    rate_q <= rate_in_eff;
                end
            end
            if (bit_done) begin
                phase <= phase_nxt;
            end
            if (tail_load) begin
                tail_cnt <= TCW'(K - 1);
            end
            if (tail_step) begin
                sreg     <= {1'b0, sreg[SW-1:1]};
                tail_cnt <= tail_cnt - TCW'(1);
            end
            // Frame close wins over the final tail shift: next frame starts from zero state
            if (frame_end) begin
                sreg   <= '0;
                phase  <= 2'd0;
                busy_q <= 1'b0;
            end
        end
    end

    assign busy = busy_q;

endmodule

// File: tb/tb_conv_encoder_punct.sv
`timescale 1ns/1ps
// Bench for conv_encoder_punct: K=3 (7,5) code, one instance with tail termination and one without.
// Frames are driven bit by bit; coded bits are collected on handshakes and compared with hand-derived sequences.
// Random out_ready stalls exercise hold-while-stalled; a mid-frame reset checks abort and clean restart.
module tb_conv_encoder_punct;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [1:0] rate;
    logic       in_valid;
    logic       in_data;
    logic       in_last;
    logic       out_ready;
    logic       sel;

    logic in_valid0, in_ready0, out_valid0, out_bit0, out_last0, busy0;
    logic in_valid1, in_ready1, out_valid1, out_bit1, out_last1, busy1;
    logic o_in_ready, o_valid, o_bit, o_last, o_busy;

    assign in_valid0  = in_valid & ~sel;
    assign in_valid1  = in_valid & sel;
    assign o_in_ready = sel ? in_ready1  : in_ready0;
    assign o_valid    = sel ? out_valid1 : out_valid0;
    assign o_bit      = sel ? out_bit1   : out_bit0;
    assign o_last     = sel ? out_last1  : out_last0;
    assign o_busy     = sel ? busy1      : busy0;

    conv_encoder_punct #(.K(3), .G0(3'b111), .G1(3'b101), .TERMINATE(1'b1)) dut_term (
        .clk(clk), .reset(reset), .rate(rate),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid0), .out_ready(out_ready), .out_bit(out_bit0), .out_last(out_last0),
        .busy(busy0)
    );

    conv_encoder_punct #(.K(3), .G0(3'b111), .G1(3'b101), .TERMINATE(1'b0)) dut_noterm (
        .clk(clk), .reset(reset), .rate(rate),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid1), .out_ready(out_ready), .out_bit(out_bit1), .out_last(out_last1),
        .busy(busy1)
    );

    typedef struct {
        logic        sel;       // 0: terminated instance, 1: unterminated instance
        logic [1:0]  rate;      // rate at frame start
        logic [1:0]  rate2;     // rate driven after the first bit is accepted
        int          n_in;
        logic [3:0]  din;       // din[i] is the i-th information bit
        bit          bp;        // random out_ready stalls
        int          n_out;
        logic [11:0] exp_bits;  // expected coded bits, first bit at [11]
    } vec_t;

    localparam int NV = 12;
    vec_t vecs[NV];

    int          checks   = 0;
    int          failures = 0;

    logic [11:0] got;
    int          n_got;
    int          last_pos;
    int          n_last;
    int          prop_err;
    int          lat;
    bit          done;
    logic        busy_end;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Drives one frame starting at a negedge and returns at a negedge after the
    // last coded-bit handshake (or after `abort` handshakes, when nonzero).
    task automatic run_frame(input logic s, input logic [1:0] r, input logic [1:0] r2,
                             input int n_in, input logic [3:0] din, input bit bp, input int abort);
        int   in_idx;
        int   cyc;
        int   acc_cyc;
        logic acc;
        logic have_prev;
        logic prev_bit;
        logic prev_last;
        sel = s; rate = r;
        in_idx = 0; cyc = 0; acc_cyc = -1;
        have_prev = 1'b0; prev_bit = 1'b0; prev_last = 1'b0;
        got = '0; n_got = 0; last_pos = -1; n_last = 0; prop_err = 0; lat = -1; done = 1'b0;
        while (!done && cyc < 300) begin
            in_valid  = (in_idx < n_in);
            in_data   = (in_idx < n_in) ? din[in_idx[1:0]] : 1'b0;
            in_last   = (in_idx == n_in - 1);
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (o_valid && o_in_ready) prop_err++;
            if (have_prev && !o_valid) prop_err++;
            if (have_prev && o_valid && (o_bit !== prev_bit || o_last !== prev_last)) prop_err++;
            have_prev = o_valid && !out_ready;
            prev_bit  = o_bit;
            prev_last = o_last;
            if (o_valid && lat < 0 && acc_cyc >= 0) lat = cyc - acc_cyc;
            acc = in_valid && o_in_ready;
            if (acc && acc_cyc < 0) acc_cyc = cyc;
            if (o_valid && out_ready) begin
                if (n_got < 12) got[11 - n_got] = o_bit;
                if (o_last) begin
                    last_pos = n_got;
                    n_last++;
                    if (o_busy !== 1'b1) prop_err++;
                    done = 1'b1;
                end
                n_got++;
                if (abort > 0 && n_got >= abort) done = 1'b1;
            end
            @(negedge clk);
            cyc++;
            if (acc) begin
                in_idx++;
                if (in_idx == 1) rate = r2;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        #1 busy_end = o_busy;
    endtask

    task automatic check_frame(input int i, input vec_t v);
        check($sformatf("v%0d_done", i), 32'(done), 32'd1);
        check($sformatf("v%0d_count", i), n_got, v.n_out);
        check($sformatf("v%0d_bits", i), 32'(got), 32'(v.exp_bits));
        check($sformatf("v%0d_last_pos", i), last_pos, v.n_out - 1);
        check($sformatf("v%0d_last_cnt", i), n_last, 32'd1);
        check($sformatf("v%0d_busy_end", i), 32'(busy_end), 32'd0);
        check($sformatf("v%0d_handshake_rules", i), prop_err, 32'd0);
        if (!v.bp) check($sformatf("v%0d_latency", i), lat, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        // Sequences for inputs 1,0,1,1 on the (7,5) code: 1/2 -> 11 10 00 01 | 01 11,
        // 2/3 keeps c0 only on odd bits, 3/4 drops c0 at phase 2; tails are never punctured.
        vecs[0]  = '{1'b0, 2'b00, 2'b00, 4, 4'b1101, 1'b0, 12, 12'b111000010111};
        vecs[1]  = '{1'b0, 2'b01, 2'b01, 4, 4'b1101, 1'b0, 10, 12'b111000011100};
        vecs[2]  = '{1'b1, 2'b10, 2'b10, 3, 4'b0101, 1'b0,  4, 12'b111000000000};
        vecs[3]  = '{1'b1, 2'b10, 2'b10, 3, 4'b0101, 1'b0,  4, 12'b111000000000};
        vecs[4]  = '{1'b0, 2'b00, 2'b00, 4, 4'b1101, 1'b1, 12, 12'b111000010111};
        vecs[5]  = '{1'b0, 2'b11, 2'b11, 4, 4'b1101, 1'b0, 12, 12'b111000010111};
        vecs[6]  = '{1'b0, 2'b01, 2'b10, 4, 4'b1101, 1'b0, 10, 12'b111000011100};
        vecs[7]  = '{1'b0, 2'b10, 2'b10, 4, 4'b1101, 1'b0, 10, 12'b111001011100};
        vecs[8]  = '{1'b0, 2'b00, 2'b00, 1, 4'b0001, 1'b0,  6, 12'b111011000000};
        vecs[9]  = '{1'b1, 2'b00, 2'b00, 1, 4'b0001, 1'b0,  2, 12'b110000000000};
        vecs[10] = '{1'b1, 2'b10, 2'b10, 3, 4'b0101, 1'b1,  4, 12'b111000000000};
        vecs[11] = '{1'b0, 2'b01, 2'b01, 4, 4'b1101, 1'b1, 10, 12'b111000011100};

        reset = 1'b1; rate = 2'b00; in_valid = 1'b0; in_data = 1'b0; in_last = 1'b0;
        out_ready = 1'b0; sel = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs", {27'd0, o_in_ready, o_valid, o_bit, o_last, o_busy}, 32'd0);
        check("reset_outputs_noterm", {27'd0, in_ready1, out_valid1, out_bit1, out_last1, busy1}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("reset_release_ready", 32'(o_in_ready), 32'd1);

        for (int i = 0; i < NV; i++) begin
            run_frame(vecs[i].sel, vecs[i].rate, vecs[i].rate2, vecs[i].n_in,
                      vecs[i].din, vecs[i].bp, 0);
            check_frame(i, vecs[i]);
        end

        // Abort a 1/2-rate frame after its 5th coded bit; c1 of bit 3 is then pending
        run_frame(1'b0, 2'b00, 2'b00, 4, 4'b1101, 1'b0, 5);
        check("abort_count", n_got, 32'd5);
        check("abort_bits", 32'(got[11:7]), 32'b11100);
        check("abort_pending_valid", 32'(o_valid), 32'd1);
        reset = 1'b1;
        #1;
        check("abort_outputs", {27'd0, o_in_ready, o_valid, o_bit, o_last, o_busy}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        check("abort_release_ready", 32'(o_in_ready), 32'd1);
        check("abort_release_busy", 32'(o_busy), 32'd0);
        @(negedge clk);
        run_frame(vecs[0].sel, vecs[0].rate, vecs[0].rate2, vecs[0].n_in,
                  vecs[0].din, vecs[0].bp, 0);
        check_frame(100, vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
